// File: rtl/bmp_draw_ctrl.sv
// Memory-mapped bitmap blitter: walks the image ROM (directory, header, pixels) and writes visible pixels to the framebuffer.
// Optional BMP_TRANSPARENT_EN: pixels whose colour equals TRANSP are skipped like clipped pixels.
module bmp_draw_ctrl #(
  parameter logic [15:0] BASE_ADDR = 16'hC008,
  parameter int          XDIM      = 640,
  parameter int          YDIM      = 480,
  parameter int          ROM_AW    = 16,
  parameter int          FB_AW     = 19,
  parameter logic [8:0]  TRANSP    = 9'h1FF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       addr,
  input  logic              mm_we,
  input  logic              mm_re,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              rd_hit,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              fb_we,
  output logic [FB_AW-1:0]  fb_addr,
  output logic [8:0]        fb_wdata,
  input  logic              fb_rdy,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {S_IDLE, S_DIR, S_HDRW, S_HDRH, S_PRD, S_PWR, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [9:0]        x_q, x_d, xl_q, xl_d, col_q, col_d, width_q, width_d;
  logic [8:0]        y_q, y_d, yl_q, yl_d, row_q, row_d, height_q, height_d;
  logic [4:0]        idx_q, idx_d;
  logic              err_q, err_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d, base_q, base_d;

  logic sel_x, sel_y, sel_c, wr_cmd, go, start;
  logic [10:0]      xpos;
  logic [9:0]       ypos;
  logic             visible, transp_hit, draw_px, last_px;
  logic [FB_AW-1:0] pix_addr;
  logic             wdata_unused;

  assign sel_x  = (addr == BASE_ADDR);
  assign sel_y  = (addr == BASE_ADDR + 16'd1);
  assign sel_c  = (addr == BASE_ADDR + 16'd2);
  assign wr_cmd = mm_we & sel_c;
  assign go     = wr_cmd & wdata[15];
  assign busy   = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done   = (state_q == S_FIN);
  assign start  = go & ~busy;
  assign rd_hit = mm_re & (sel_x | sel_y | sel_c);
  assign wdata_unused = ^wdata[13:10];

  always_comb begin
    rdata = 16'h0000;
    if (rd_hit) begin
      if (sel_x)      rdata = {6'b0, x_q};
      else if (sel_y) rdata = {7'b0, y_q};
      else            rdata = {busy, err_q, 9'b0, idx_q};
    end
  end

  // 11b/10b sums cannot wrap, so any off-screen position fails the compare.
  assign xpos     = {1'b0, xl_q} + {1'b0, col_q};
  assign ypos     = {1'b0, yl_q} + {1'b0, row_q};
  assign visible  = (xpos < 11'(XDIM)) && (ypos < 10'(YDIM));
  assign pix_addr = FB_AW'(ypos) * FB_AW'(XDIM) + FB_AW'(xpos);
  assign last_px  = (col_q == width_q - 10'd1) && (row_q == height_q - 9'd1);

`ifdef BMP_TRANSPARENT_EN
  assign transp_hit = (rom_data[8:0] == TRANSP);
`else
  logic transp_unused;
  assign transp_unused = ^TRANSP;
  assign transp_hit    = 1'b0;
`endif

  assign draw_px = visible & ~transp_hit;

  // rom_addr is presented from the next-state value so the synchronous ROM
  // returns data in the cycle following each address step.
  assign rom_addr = rom_addr_d;
  assign fb_addr  = fb_we ? pix_addr : '0;
  assign fb_wdata = fb_we ? rom_data[8:0] : 9'h000;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    idx_d      = idx_q;
    err_d      = err_q;
    rom_addr_d = rom_addr_q;
    xl_d       = xl_q;
    yl_d       = yl_q;
    base_d     = base_q;
    width_d    = width_q;
    height_d   = height_q;
    row_d      = row_q;
    col_d      = col_q;
    fb_we      = 1'b0;

    if (mm_we && sel_x) x_d = wdata[9:0];
    if (mm_we && sel_y) y_d = wdata[8:0];
    if (wr_cmd) begin
      idx_d = wdata[4:0];
      if (wdata[14]) err_d = 1'b0;
    end
    if (go && busy) err_d = 1'b1;

    case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (start) begin
          xl_d       = x_q;
          yl_d       = y_q;
          rom_addr_d = ROM_AW'(wdata[4:0]);
          state_d    = S_DIR;
        end
      end
      S_DIR: begin
        base_d     = ROM_AW'(rom_data);
        rom_addr_d = ROM_AW'(rom_data);
        state_d    = S_HDRW;
      end
      S_HDRW: begin
        width_d    = rom_data[9:0];
        rom_addr_d = base_q + ROM_AW'(1);
        state_d    = S_HDRH;
      end
      S_HDRH: begin
        height_d = rom_data[8:0];
        if ((width_q == 10'd0) || (rom_data[8:0] == 9'd0)) begin
          state_d = S_FIN;
        end else begin
          row_d      = 9'd0;
          col_d      = 10'd0;
          rom_addr_d = base_q + ROM_AW'(2);
          state_d    = S_PRD;
        end
      end
      S_PRD: state_d = S_PWR;
      S_PWR: begin
        fb_we = draw_px;
        if (!draw_px || fb_rdy) begin
          if (col_q == width_q - 10'd1) begin
            col_d = 10'd0;
            row_d = row_q + 9'd1;
          end else begin
            col_d = col_q + 10'd1;
          end
          rom_addr_d = rom_addr_q + ROM_AW'(1);
          state_d    = last_px ? S_FIN : S_PRD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= 10'd0;
      y_q        <= 9'd0;
      idx_q      <= 5'd0;
      err_q      <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    xl_q     <= xl_d;
    yl_q     <= yl_d;
    base_q   <= base_d;
    width_q  <= width_d;
    height_q <= height_d;
    row_q    <= row_d;
    col_q    <= col_d;
  end

endmodule

// File: tb/tb_bmp_draw_ctrl.sv
// Directed bench for bmp_draw_ctrl: small image ROM, framebuffer write log, hand-computed expectations.
module tb_bmp_draw_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        mm_we = 1'b0;
  logic        mm_re = 1'b0;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        rd_hit;
  logic [15:0] rom_addr;
  logic [15:0] rom_data = 16'h0000;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [8:0]  fb_wdata;
  logic        fb_rdy = 1'b1;
  logic        busy;
  logic        done;

  bmp_draw_ctrl dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .mm_we(mm_we), .mm_re(mm_re),
    .wdata(wdata), .rdata(rdata), .rd_hit(rd_hit), .rom_addr(rom_addr),
    .rom_data(rom_data), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .fb_rdy(fb_rdy), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [0:255];
  always @(posedge clk) rom_data <= rom[rom_addr[7:0]];

  int unsigned fa[$];
  int unsigned fd[$];
  int          done_cnt = 0;
  always @(posedge clk) begin
    if (fb_we && fb_rdy) begin
      fa.push_back(32'(fb_addr));
      fd.push_back(32'(fb_wdata));
    end
    if (done) done_cnt++;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic mm_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; wdata = d; mm_we = 1'b1;
    @(negedge clk);
    mm_we = 1'b0;
  endtask

  task automatic mm_read(input logic [15:0] a, output logic [15:0] v, output logic hit);
    @(negedge clk);
    addr = a; mm_re = 1'b1;
    #1;
    v = rdata; hit = rd_hit;
    mm_re = 1'b0;
  endtask

  // lat = cycle in which done is high, counting the GO write cycle as 0
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n + 1;
        break;
      end
    end
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_fb_we(output logic seen);
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (fb_we) begin
        seen = 1'b1;
        break;
      end
    end
    chk("fb_we_seen", 32'(seen), 1);
  endtask

  logic [15:0] rv;
  logic        hit, seen;
  int          lat, dc0;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[1] = 16'h0050; rom[2] = 16'h0060; rom[3] = 16'h0040; rom[4] = 16'h0070;
    rom[8'h40] = 16'd2; rom[8'h41] = 16'd2;
    rom[8'h42] = 16'd1; rom[8'h43] = 16'd2; rom[8'h44] = 16'd3; rom[8'h45] = 16'd4;
    rom[8'h50] = 16'd2; rom[8'h51] = 16'd2;
    rom[8'h52] = 16'd5; rom[8'h53] = 16'd6; rom[8'h54] = 16'd7; rom[8'h55] = 16'd8;
    rom[8'h60] = 16'd3; rom[8'h61] = 16'd0;
    rom[8'h70] = 16'd2; rom[8'h71] = 16'd2;
    rom[8'h72] = 16'h009; rom[8'h73] = 16'h1FF; rom[8'h74] = 16'h00A; rom[8'h75] = 16'h00B;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fb_we", 32'(fb_we), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_done", 32'(done), 0);
    chk("rst_fb_addr", 32'(fb_addr), 0);
    chk("rst_fb_wdata", 32'(fb_wdata), 0);
    mm_read(16'hC00A, rv, hit);
    chk("rst_status", 32'(rv), 0);
    chk("rst_rd_hit", 32'(hit), 1);
    mm_read(16'hC00B, rv, hit);
    chk("miss_rd_hit", 32'(hit), 0);

    // 1: basic 2x2 draw
    mm_write(16'hC008, 16'd10);
    mm_write(16'hC009, 16'd20);
    mm_read(16'hC008, rv, hit);
    chk("x_readback", 32'(rv), 10);
    fa.delete(); fd.delete(); dc0 = done_cnt;
    mm_write(16'hC00A, 16'h8003);
    #1;
    chk("t1_busy", 32'(busy), 1);
    wait_done(lat);
    chk("t1_latency", 32'(lat), 12);
    chk("t1_nwrites", 32'(fa.size()), 4);
    if (fa.size() == 4) begin
      chk("t1_a0", fa[0], 12810); chk("t1_d0", fd[0], 1);
      chk("t1_a1", fa[1], 12811); chk("t1_d1", fd[1], 2);
      chk("t1_a2", fa[2], 13450); chk("t1_d2", fd[2], 3);
      chk("t1_a3", fa[3], 13451); chk("t1_d3", fd[3], 4);
    end
    chk("t1_fin_busy", 32'(busy), 0);
    @(posedge clk); #1;
    chk("t1_done_1cyc", 32'(done), 0);
    chk("t1_done_cnt", 32'(done_cnt - dc0), 1);

    // 2: bottom-right corner, three pixels clipped
    mm_write(16'hC008, 16'd639);
    mm_write(16'hC009, 16'd479);
    fa.delete(); fd.delete(); dc0 = done_cnt;
    mm_write(16'hC00A, 16'h8001);
    wait_done(lat);
    chk("t2_latency", 32'(lat), 12);
    chk("t2_nwrites", 32'(fa.size()), 1);
    if (fa.size() == 1) begin
      chk("t2_addr", fa[0], 307199);
      chk("t2_data", fd[0], 5);
    end
    @(posedge clk); #1;
    chk("t2_done_cnt", 32'(done_cnt - dc0), 1);

    // 3: framebuffer stall on first pixel
    mm_write(16'hC008, 16'd10);
    mm_write(16'hC009, 16'd20);
    fa.delete(); fd.delete();
    fb_rdy = 1'b0;
    mm_write(16'hC00A, 16'h8003);
    wait_fb_we(seen);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_we", 32'(fb_we), 1);
      chk("t3_hold_addr", 32'(fb_addr), 12810);
      chk("t3_hold_data", 32'(fb_wdata), 1);
      @(posedge clk); #1;
    end
    fb_rdy = 1'b1;
    wait_done(lat);
    chk("t3_nwrites", 32'(fa.size()), 4);
    if (fa.size() == 4) chk("t3_a3", fa[3], 13451);

    // 4: GO and X write during a draw
    fa.delete(); fd.delete();
    mm_write(16'hC00A, 16'h8003);
    mm_write(16'hC00A, 16'h8003);
    mm_write(16'hC008, 16'd100);
    mm_read(16'hC00A, rv, hit);
    chk("t4_status_err", 32'(rv), 32'hC003);
    wait_done(lat);
    chk("t4_nwrites", 32'(fa.size()), 4);
    if (fa.size() == 4) chk("t4_old_x", fa[0], 12810);
    mm_read(16'hC008, rv, hit);
    chk("t4_new_x", 32'(rv), 100);
    mm_write(16'hC00A, 16'h4000);
    mm_read(16'hC00A, rv, hit);
    chk("t4_err_clr", 32'(rv), 0);

    // 5: zero-height image
    fa.delete(); fd.delete();
    mm_write(16'hC00A, 16'h8002);
    wait_done(lat);
    chk("t5_latency", 32'(lat), 4);
    chk("t5_nwrites", 32'(fa.size()), 0);

    // 7: image with a 9'h1FF pixel
    mm_write(16'hC008, 16'd10);
    fa.delete(); fd.delete();
    mm_write(16'hC00A, 16'h8004);
    wait_done(lat);
`ifdef BMP_TRANSPARENT_EN
    chk("t7_nwrites", 32'(fa.size()), 3);
    if (fa.size() == 3) chk("t7_a1", fa[1], 13450);
`else
    chk("t7_nwrites", 32'(fa.size()), 4);
    if (fa.size() == 4) chk("t7_d1", fd[1], 32'h1FF);
`endif

    // 6: asynchronous reset in the middle of a draw
    mm_write(16'hC00A, 16'h8003);
    mm_write(16'hC00A, 16'h8003);
    wait_fb_we(seen);
    dc0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_fb_we", 32'(fb_we), 0);
    chk("t6_busy", 32'(busy), 0);
    #2 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_no_done", 32'(done_cnt - dc0), 0);
    mm_read(16'hC00A, rv, hit);
    chk("t6_status", 32'(rv), 0);
    mm_read(16'hC008, rv, hit);
    chk("t6_x_reset", 32'(rv), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
